// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and a
// counter-width helper.
// Ports: none (package).
package rst_seq_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_HOLD = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_REL  = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE = 2'd3;

  // Counter width for a counter that must hold values up to v-1.
  // The extra bit keeps the width at least 1 for v==1 and leaves headroom.
  function automatic int cnt_w(input int v);
    return $clog2(v) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for a level crossing into clk.
// Ports: clk, rst (sync, active-high), d (async input), q (synchronized, 2-cycle latency).
// Both flops reset to 0 so a freshly reset design always sees the input as deasserted.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC = "TRUE" *) logic meta;
  (* ASYNC = "TRUE" *) logic sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Power-up / recovery reset sequencer: filters a synchronized PLL lock, then
// releases N_STAGES active-low domain resets one by one, STAGE_DLY cycles apart.
// Ports: sys_clk, sys_rst (sync, active-high), i_pll_locked (async), i_soft_rst,
//        o_rst_n[N_STAGES] (bit 0 first), o_done, o_state, o_timeout.
// Optional macro RST_SEQ_TIMEOUT_EN: bounds WAIT_LOCK to TIMEOUT cycles and
// pulses o_timeout before retrying from HOLD; otherwise o_timeout is tied 0.
module reset_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int STAGE_DLY   = 16,
  parameter int LOCK_FILTER = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                i_pll_locked,
  input  logic                i_soft_rst,
  output logic [N_STAGES-1:0] o_rst_n,
  output logic                o_done,
  output logic [ST_W-1:0]     o_state,
  output logic                o_timeout
);

  localparam int FW = cnt_w(LOCK_FILTER);
  localparam int DW = cnt_w(STAGE_DLY);
  localparam int IW = cnt_w(N_STAGES);

  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);

  logic                lock_s;
  logic [ST_W-1:0]     state_q;
  logic [ST_W-1:0]     state_d;
  logic [FW-1:0]       filt_cnt;
  logic [DW-1:0]       dly_cnt;
  logic [IW-1:0]       idx;
  logic [N_STAGES-1:0] rst_n_q;
  logic [N_STAGES-1:0] rst_n_d;
  logic                done_q;
  logic                done_d;

  logic lock_ok;   // filter satisfied this cycle
  logic rel_fire;  // a stage releases on this edge (if not aborted)
  logic rel_last;  // the final stage releases on this edge
  logic abort;     // lock lost or software restart (RELEASE/DONE)
  logic to_fire;   // WAIT_LOCK timeout on this edge

  sync_2ff u_lock_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (i_pll_locked),
    .q   (lock_s)
  );

  assign lock_ok  = (state_q == ST_WAIT) && lock_s && (filt_cnt == FILT_LAST);
  assign rel_fire = (state_q == ST_REL) && (dly_cnt == DLY_LAST);
  assign rel_last = rel_fire && (idx == IDX_LAST);
  assign abort    = i_soft_rst || !lock_s;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] to_cnt;
  logic          to_pulse;

  // A successful lock exit wins over a timeout landing on the same cycle.
  assign to_fire = (state_q == ST_WAIT) && (to_cnt == TO_LAST) && !lock_ok;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      to_cnt   <= '0;
      to_pulse <= 1'b0;
    end else begin
      to_cnt   <= (state_q == ST_WAIT && state_d == ST_WAIT) ? to_cnt + 1'b1 : '0;
      to_pulse <= to_fire;
    end
  end

  assign o_timeout = to_pulse;
`else
  localparam logic [31:0] TIMEOUT_V = 32'(TIMEOUT);
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_V;
  assign to_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // State register; the reset outputs are registered too so that a domain
  // reset never glitches while idx or the state changes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_HOLD;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. In WAIT_LOCK a low lock only restarts the filter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HOLD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_soft_rst)   state_d = ST_HOLD;
        else if (lock_ok) state_d = ST_REL;
        else if (to_fire) state_d = ST_HOLD;
      end
      ST_REL: begin
        if (abort)         state_d = ST_HOLD;
        else if (rel_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (abort) state_d = ST_HOLD;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Output logic, computed from the next state so outputs change on the same
  // edge as the state. Any move to HOLD re-asserts every domain at once.
  always_comb begin
    rst_n_d = '0;
    done_d  = 1'b0;
    unique case (state_d)
      ST_REL: begin
        rst_n_d = rst_n_q;
        for (int i = 0; i < N_STAGES; i++) begin
          if (rel_fire && (idx == IW'(i))) rst_n_d[i] = 1'b1;
        end
      end
      ST_DONE: begin
        rst_n_d = '1;
        done_d  = 1'b1;
      end
      default: begin
        rst_n_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Counters clear whenever their state is left, so none can wrap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      filt_cnt <= '0;
      dly_cnt  <= '0;
      idx      <= '0;
    end else begin
      filt_cnt <= (state_q == ST_WAIT && state_d == ST_WAIT && lock_s) ?
                  filt_cnt + 1'b1 : '0;
      if (state_q == ST_REL && state_d == ST_REL) begin
        dly_cnt <= rel_fire ? '0 : dly_cnt + 1'b1;
        idx     <= rel_fire ? idx + 1'b1 : idx;
      end else begin
        dly_cnt <= '0;
        idx     <= '0;
      end
    end
  end

  assign o_rst_n = rst_n_q;
  assign o_done  = done_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
module tb_reset_seq_ctrl;

  localparam int N   = 4;
  localparam int DLY = 16;
  localparam int LF  = 8;
  localparam int TO  = 32;
`ifdef RST_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         i_pll_locked = 1'b0;
  logic         i_soft_rst = 1'b0;
  logic [N-1:0] o_rst_n;
  logic         o_done;
  logic [1:0]   o_state;
  logic         o_timeout;

  int vecs = 0;
  int errs = 0;

  always #5 sys_clk = ~sys_clk;

  reset_seq_ctrl #(
    .N_STAGES(N), .STAGE_DLY(DLY), .LOCK_FILTER(LF), .TIMEOUT(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .i_pll_locked(i_pll_locked),
    .i_soft_rst(i_soft_rst), .o_rst_n(o_rst_n), .o_done(o_done),
    .o_state(o_state), .o_timeout(o_timeout)
  );

  // Reference model: phase (0 hold, 1 wait, 2 release, 3 done), run of
  // consecutive high lock samples, cycles elapsed since release began.
  int m_ph = 0, m_run = 0, m_el = 0, m_to = 0;
  bit m_s1 = 0, m_s2 = 0, m_tp = 0;

  // Released-domain count is simply elapsed release time / gap.
  function automatic logic [N-1:0] exp_rst_n(input int ph, input int el);
    logic [N-1:0] r;
    r = '0;
    if (ph == 3) r = '1;
    else if (ph == 2) for (int i = 0; i < N; i++) r[i] = (i < el / DLY);
    return r;
  endfunction

  // Advance one clock edge; the model steps with the inputs held before it.
  task automatic tick();
    int ph, run, el, to;
    bit tp, ls, lock_ok;
    ph = m_ph; run = m_run; el = m_el; to = m_to; tp = 0; ls = m_s2;
    lock_ok = ls && (m_run + 1 == LF);
    if (sys_rst) begin
      ph = 0; run = 0; el = 0; to = 0;
    end else begin
      case (m_ph)
        0: begin ph = 1; run = 0; to = 0; end
        1: begin
          tp = TO_EN && (m_to == TO - 1) && !lock_ok;
          if (i_soft_rst) ph = 0;
          else if (lock_ok) begin ph = 2; el = 0; end
          else if (tp) ph = 0;
          run = ls ? m_run + 1 : 0;
          to  = m_to + 1;
          if (ph != 1) begin run = 0; to = 0; end
        end
        2: if (i_soft_rst || !ls) ph = 0;
           else begin el = m_el + 1; if (el == N * DLY) ph = 3; end
        default: if (i_soft_rst || !ls) ph = 0;
      endcase
    end
    @(posedge sys_clk);
    #1;
    m_s2 = sys_rst ? 1'b0 : m_s1;
    m_s1 = sys_rst ? 1'b0 : i_pll_locked;
    m_ph = ph; m_run = run; m_el = el; m_to = to; m_tp = tp;
  endtask

  task automatic apply_reset(input logic pll);
    i_pll_locked = pll; i_soft_rst = 0; sys_rst = 1;
    repeat (3) tick();
    sys_rst = 0;
  endtask

  task automatic test_reset();
    i_pll_locked = 1; sys_rst = 1;
    repeat (3) tick();
    vecs++; if (o_rst_n !== 4'b0000) begin errs++; $display("FAIL reset_rst_n got %b want 0000", o_rst_n); end
    vecs++; if (o_done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", o_done); end
    vecs++; if (o_state !== 2'd0) begin errs++; $display("FAIL reset_state got %0d want 0", o_state); end
    vecs++; if (o_timeout !== 1'b0) begin errs++; $display("FAIL reset_timeout got %b want 0", o_timeout); end
  endtask

  task automatic test_sequence();
    int           ck[7] = '{9, 10, 26, 42, 58, 73, 74};
    logic [3:0]   rn[7] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'h7, 4'hF};
    logic         dn[7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [1:0]   st[7] = '{1, 2, 2, 2, 2, 2, 3};
    apply_reset(1'b1);
    for (int k = 1; k <= 76; k++) begin
      tick();
      for (int j = 0; j < 7; j++) if (k == ck[j]) begin
        vecs++; if (o_rst_n !== rn[j]) begin errs++; $display("FAIL seq_rst_n k=%0d got %b want %b", k, o_rst_n, rn[j]); end
        vecs++; if (o_done !== dn[j]) begin errs++; $display("FAIL seq_done k=%0d got %b want %b", k, o_done, dn[j]); end
        vecs++; if (o_state !== st[j]) begin errs++; $display("FAIL seq_state k=%0d got %0d want %0d", k, o_state, st[j]); end
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset(1'b1);
    for (int k = 1; k <= 17; k++) begin
      i_pll_locked = (k != 6);
      tick();
      if (k <= 16) begin
        vecs++; if (o_rst_n !== 4'b0000) begin errs++; $display("FAIL glitch_rst_n k=%0d got %b want 0000", k, o_rst_n); end
      end
      if (k == 10 || k == 15) begin
        vecs++; if (o_state !== 2'd1) begin errs++; $display("FAIL glitch_wait k=%0d got %0d want 1", k, o_state); end
      end
      if (k == 16) begin
        vecs++; if (o_state !== 2'd2) begin errs++; $display("FAIL glitch_release k=%0d got %0d want 2", k, o_state); end
      end
    end
  endtask

  task automatic test_lock_loss();
    int n = 0;
    while (o_done !== 1'b1 && n < 200) begin tick(); n++; end
    vecs++; if (o_done !== 1'b1) begin errs++; $display("FAIL loss_reach_done got %b want 1 (timeout)", o_done); end
    i_pll_locked = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k <= 2) begin
        vecs++; if (o_rst_n !== 4'hF || o_state !== 2'd3) begin errs++; $display("FAIL loss_sync k=%0d got %b/%0d want 1111/3", k, o_rst_n, o_state); end
      end
      if (k == 3) begin
        vecs++; if (o_rst_n !== 4'h0 || o_done !== 1'b0 || o_state !== 2'd0) begin
          errs++; $display("FAIL loss_hold got %b/%b/%0d want 0000/0/0", o_rst_n, o_done, o_state); end
      end
      if (k == 4) begin
        vecs++; if (o_state !== 2'd1) begin errs++; $display("FAIL loss_wait got %0d want 1", o_state); end
      end
    end
    i_pll_locked = 1;
    for (int k = 1; k <= 74; k++) begin
      tick();
      if (k == 73 || k == 74) begin
        vecs++; if (o_done !== (k == 74)) begin errs++; $display("FAIL loss_redo k=%0d got %b want %b", k, o_done, k == 74); end
      end
    end
  endtask

  task automatic test_soft_release();
    int n = 0;
    i_soft_rst = 1; tick(); i_soft_rst = 0;
    while (o_rst_n !== 4'b0011 && n < 200) begin tick(); n++; end
    vecs++; if (o_rst_n !== 4'b0011) begin errs++; $display("FAIL soft_reach got %b want 0011 (timeout)", o_rst_n); end
    i_soft_rst = 1; tick(); i_soft_rst = 0;
    vecs++; if (o_rst_n !== 4'h0 || o_state !== 2'd0) begin errs++; $display("FAIL soft_abort got %b/%0d want 0000/0", o_rst_n, o_state); end
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 8) begin vecs++; if (o_state !== 2'd1) begin errs++; $display("FAIL soft_wait got %0d want 1", o_state); end end
      if (k == 9) begin vecs++; if (o_state !== 2'd2) begin errs++; $display("FAIL soft_rel got %0d want 2", o_state); end end
      if (k == 24) begin vecs++; if (o_rst_n !== 4'h0) begin errs++; $display("FAIL soft_pre got %b want 0000", o_rst_n); end end
      if (k == 25) begin vecs++; if (o_rst_n !== 4'h1) begin errs++; $display("FAIL soft_first got %b want 0001", o_rst_n); end end
    end
  endtask

  task automatic test_simultaneous();
    i_soft_rst = 1; tick(); i_soft_rst = 0;
    repeat (24) tick();
    vecs++; if (o_state !== 2'd2 || o_rst_n !== 4'h0) begin errs++; $display("FAIL simul_pre got %0d/%b want 2/0000", o_state, o_rst_n); end
    i_soft_rst = 1; tick(); i_soft_rst = 0;
    vecs++; if (o_state !== 2'd0) begin errs++; $display("FAIL simul_state got %0d want 0", o_state); end
    for (int k = 0; k < 6; k++) begin
      vecs++; if (o_rst_n[0] !== 1'b0) begin errs++; $display("FAIL simul_bit0 k=%0d got %b want 0", k, o_rst_n[0]); end
      tick();
    end
  endtask

  // Timeout pulse coincides with the return to HOLD; pulses are TO+1 apart.
  task automatic test_timeout();
    logic ep;
    apply_reset(1'b0);
    for (int k = 1; k <= 70; k++) begin
      tick();
      ep = TO_EN && (k == TO + 1 || k == 2 * TO + 2);
      vecs++; if (o_timeout !== ep) begin errs++; $display("FAIL timeout_pulse k=%0d got %b want %b", k, o_timeout, ep); end
      vecs++; if (o_state !== (ep ? 2'd0 : 2'd1)) begin errs++; $display("FAIL timeout_state k=%0d got %0d want %0d", k, o_state, ep ? 0 : 1); end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    apply_reset(1'b0);
    for (int c = 0; c < 5000; c++) begin
      if (hold == 0) begin
        i_pll_locked = ($urandom_range(0, 3) != 0);
        hold = i_pll_locked ? $urandom_range(1, 160) : $urandom_range(1, 12);
      end
      hold--;
      i_soft_rst = ($urandom_range(0, 249) == 0);
      sys_rst    = ($urandom_range(0, 999) == 0);
      tick();
      vecs++; if (o_rst_n !== exp_rst_n(m_ph, m_el)) begin errs++; $display("FAIL rand_rst_n c=%0d got %b want %b", c, o_rst_n, exp_rst_n(m_ph, m_el)); end
      vecs++; if (o_done !== (m_ph == 3)) begin errs++; $display("FAIL rand_done c=%0d got %b want %b", c, o_done, m_ph == 3); end
      vecs++; if (o_state !== 2'(m_ph)) begin errs++; $display("FAIL rand_state c=%0d got %0d want %0d", c, o_state, m_ph); end
      vecs++; if (o_timeout !== m_tp) begin errs++; $display("FAIL rand_timeout c=%0d got %b want %b", c, o_timeout, m_tp); end
    end
    i_soft_rst = 0; sys_rst = 0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_glitch();
    test_lock_loss();
    test_soft_release();
    test_simultaneous();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
